// File: rtl/adder_error_monitor_if.sv
// Sample handshake between the adder under test and its accuracy monitor:
// the exact/approximate sum pair, qualified by a valid/ready pair.
interface adder_error_monitor_if #(
    parameter int SUM_W = 17
);
    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] exact_sum;
    logic [SUM_W-1:0] approx_sum;

    modport master (output in_valid, exact_sum, approx_sum, input in_ready);
    modport slave  (input in_valid, exact_sum, approx_sum, output in_ready);
endinterface

// File: rtl/adder_error_monitor.sv
// Accuracy monitor for an approximate 16-bit adder: a two-stage pipeline that accumulates
// error count, summed |ED| (saturating) and max |ED| over a run of N samples.
module adder_error_monitor #(
    parameter int SUM_W = 17,
    parameter int CNT_W = 24,
    parameter int ACC_W = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    adder_error_monitor_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [ACC_W-1:0]     sum_ed,
    output logic [SUM_W-1:0]     max_ed,
    output logic                 acc_sat
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // The subtraction is one bit wider than the operands so the borrow selects the direction.
    function automatic logic [SUM_W-1:0] abs_diff(input logic [SUM_W-1:0] a,
                                                  input logic [SUM_W-1:0] b);
        logic [SUM_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[SUM_W]) begin
            abs_diff = b - a;
        end else begin
            abs_diff = diff[SUM_W-1:0];
        end
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] target_r;
    logic [CNT_W-1:0] accepted_r;
    logic [CNT_W-1:0] sample_count_r;
    logic [CNT_W-1:0] err_count_r;
    logic [ACC_W-1:0] sum_ed_r;
    logic [SUM_W-1:0] max_ed_r;
    logic             acc_sat_r;
    logic             busy_r;
    logic             done_r;

    logic             s1_valid_r;
    logic             s1_mismatch_r;
    logic [SUM_W-1:0] s1_ed_r;

    logic             ready_s;
    logic             xfer_s;
    logic [CNT_W-1:0] accepted_next_s;
    logic [SUM_W-1:0] ed_s;
    logic [ACC_W:0]   sum_ext_s;

    // Handshake decode, next-accepted count and stage-2 adder with carry for saturation.
    always_comb begin
        ready_s         = (state_r == ST_RUN) && (accepted_r < target_r);
        xfer_s          = bus.in_valid && ready_s;
        accepted_next_s = accepted_r + {{(CNT_W-1){1'b0}}, 1'b1};
        ed_s            = abs_diff(bus.exact_sum, bus.approx_sum);
        sum_ext_s       = {1'b0, sum_ed_r} + (ACC_W+1)'(s1_ed_r);
    end

    assign bus.in_ready = ready_s;

    // Stage 1: capture the error distance of each transferred pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r    <= 1'b0;
            s1_mismatch_r <= 1'b0;
            s1_ed_r       <= {SUM_W{1'b0}};
        end else begin
            s1_valid_r <= xfer_s;
            if (xfer_s) begin
                s1_ed_r       <= ed_s;
                s1_mismatch_r <= (ed_s != {SUM_W{1'b0}});
            end else begin
                s1_ed_r       <= s1_ed_r;
                s1_mismatch_r <= s1_mismatch_r;
            end
        end
    end

    // Run controller and stage-2 metric accumulation; a start clear overrides accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            target_r       <= {CNT_W{1'b0}};
            accepted_r     <= {CNT_W{1'b0}};
            sample_count_r <= {CNT_W{1'b0}};
            err_count_r    <= {CNT_W{1'b0}};
            sum_ed_r       <= {ACC_W{1'b0}};
            max_ed_r       <= {SUM_W{1'b0}};
            acc_sat_r      <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            if (s1_valid_r) begin
                sample_count_r <= sample_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                err_count_r    <= err_count_r + {{(CNT_W-1){1'b0}}, s1_mismatch_r};
                if (sum_ext_s[ACC_W]) begin
                    sum_ed_r  <= {ACC_W{1'b1}};
                    acc_sat_r <= 1'b1;
                end else begin
                    sum_ed_r  <= sum_ext_s[ACC_W-1:0];
                end
                if (s1_ed_r > max_ed_r) begin
                    max_ed_r <= s1_ed_r;
                end
            end

            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        target_r       <= num_samples;
                        accepted_r     <= {CNT_W{1'b0}};
                        sample_count_r <= {CNT_W{1'b0}};
                        err_count_r    <= {CNT_W{1'b0}};
                        sum_ed_r       <= {ACC_W{1'b0}};
                        max_ed_r       <= {SUM_W{1'b0}};
                        acc_sat_r      <= 1'b0;
                        if (num_samples == {CNT_W{1'b0}}) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (xfer_s) begin
                        accepted_r <= accepted_next_s;
                        if (accepted_next_s == target_r) begin
                            state_r <= ST_DRAIN;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!s1_valid_r && (sample_count_r == target_r)) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign sample_count = sample_count_r;
    assign err_count    = err_count_r;
    assign sum_ed       = sum_ed_r;
    assign max_ed       = max_ed_r;
    assign acc_sat      = acc_sat_r;

endmodule

// File: tb/tb_adder_error_monitor.sv
// Directed self-checking bench for adder_error_monitor; a second instance built with a
// 17-bit accumulator exercises saturation.
module tb_adder_error_monitor;
    localparam int SUM_W = 17;
    localparam int CNT_W = 24;
    localparam int ACC_W = 40;
    localparam int SAT_W = 17;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             busy, done, acc_sat;
    logic [CNT_W-1:0] sample_count, err_count;
    logic [ACC_W-1:0] sum_ed;
    logic [SUM_W-1:0] max_ed;

    logic             start2;
    logic [CNT_W-1:0] num_samples2;
    logic             busy2, done2, acc_sat2;
    logic [CNT_W-1:0] sample_count2, err_count2;
    logic [SAT_W-1:0] sum_ed2;
    logic [SUM_W-1:0] max_ed2;

    int compared = 0;
    int failed   = 0;

    adder_error_monitor_if #(.SUM_W(SUM_W)) bus  ();
    adder_error_monitor_if #(.SUM_W(SUM_W)) bus2 ();

    adder_error_monitor #(.SUM_W(SUM_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .bus(bus),
        .busy(busy), .done(done), .sample_count(sample_count), .err_count(err_count),
        .sum_ed(sum_ed), .max_ed(max_ed), .acc_sat(acc_sat)
    );

    adder_error_monitor #(.SUM_W(SUM_W), .CNT_W(CNT_W), .ACC_W(SAT_W)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .num_samples(num_samples2), .bus(bus2),
        .busy(busy2), .done(done2), .sample_count(sample_count2), .err_count(err_count2),
        .sum_ed(sum_ed2), .max_ed(max_ed2), .acc_sat(acc_sat2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n);
        start = 1'b1;
        num_samples = n;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [SUM_W-1:0] e, input logic [SUM_W-1:0] a, input string nm);
        bus.in_valid   = 1'b1;
        bus.exact_sum  = e;
        bus.approx_sum = a;
        compared++;
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL %s_in_ready got %b expected 1", nm, bus.in_ready);
            failed++;
        end
        step();
    endtask

    task automatic test_reset();
        logic [108:0] outs;
        outs = {busy, done, sample_count, err_count, sum_ed, max_ed, acc_sat, bus.in_ready};
        compared++;
        if (outs !== '0) begin
            $display("FAIL reset_state got %h expected 0", outs);
            failed++;
        end
        step();
        rst_n = 1'b1;
        step();
        step();
        compared++;
        if ({bus.in_ready, busy, done} !== 3'b000) begin
            $display("FAIL idle_no_ready got %b expected 000", {bus.in_ready, busy, done});
            failed++;
        end
        // Mid-run reset with three samples in flight.
        do_start(24'd8);
        send(17'h0_0001, 17'h0_0003, "midrun0");
        send(17'h0_0001, 17'h0_0003, "midrun1");
        send(17'h0_0001, 17'h0_0003, "midrun2");
        compared++;
        if (sample_count !== 24'd2) begin
            $display("FAIL midrun_inflight got %0d expected 2", sample_count);
            failed++;
        end
        rst_n = 1'b0;
        #1;
        outs = {busy, done, sample_count, err_count, sum_ed, max_ed, acc_sat, bus.in_ready};
        compared++;
        if (outs !== '0) begin
            $display("FAIL midrun_reset got %h expected 0", outs);
            failed++;
        end
        bus.in_valid = 1'b0;
        step();
        outs = {busy, done, sample_count, err_count, sum_ed, max_ed, acc_sat, bus.in_ready};
        compared++;
        if (outs !== '0) begin
            $display("FAIL midrun_reset_edge got %h expected 0", outs);
            failed++;
        end
        rst_n = 1'b1;
        step();
        step();
        compared++;
        if ({bus.in_ready, busy, done, sample_count} !== 27'd0) begin
            $display("FAIL post_reset_idle got rdy=%b busy=%b done=%b cnt=%0d expected all 0",
                     bus.in_ready, busy, done, sample_count);
            failed++;
        end
    endtask

    task automatic test_exact_b2b();
        do_start(24'd4);
        compared++;
        if ({busy, done, bus.in_ready} !== 3'b101) begin
            $display("FAIL exact_run_flags got %b expected 101", {busy, done, bus.in_ready});
            failed++;
        end
        for (int i = 0; i < 4; i++) send(17'h0_1234, 17'h0_1234, "exact");
        compared++;
        if (bus.in_ready !== 1'b0) begin
            $display("FAIL exact_ready_drop got %b expected 0", bus.in_ready);
            failed++;
        end
        bus.in_valid = 1'b0;
        step();
        compared++;
        if ({sample_count, err_count, sum_ed, max_ed} !== {24'd4, 24'd0, 40'd0, 17'd0}) begin
            $display("FAIL exact_metrics got cnt=%0d err=%0d sum=%h max=%h expected 4/0/0/0",
                     sample_count, err_count, sum_ed, max_ed);
            failed++;
        end
        step();
        compared++;
        if ({done, busy} !== 2'b10) begin
            $display("FAIL exact_done got done=%b busy=%b expected 1/0", done, busy);
            failed++;
        end
    endtask

    task automatic test_mixed();
        do_start(24'd3);
        send(17'h1_0000, 17'h0_FFFF, "mixed0");
        send(17'h0_0010, 17'h0_0020, "mixed1");
        send(17'h0_5555, 17'h0_5555, "mixed2");
        bus.in_valid = 1'b0;
        step();
        compared++;
        if ({sample_count, err_count, sum_ed, max_ed} !== {24'd3, 24'd2, 40'h11, 17'h10}) begin
            $display("FAIL mixed_metrics got cnt=%0d err=%0d sum=%h max=%h expected 3/2/11/10",
                     sample_count, err_count, sum_ed, max_ed);
            failed++;
        end
        step();
        compared++;
        if (done !== 1'b1) begin
            $display("FAIL mixed_done got %b expected 1", done);
            failed++;
        end
    endtask

    task automatic test_stall();
        do_start(24'd2);
        send(17'h0_0003, 17'h0_0001, "stall0");
        bus.in_valid = 1'b0;
        step();
        send(17'h0_0000, 17'h0_0007, "stall1");
        // Source keeps in_valid high past N; the block must refuse it.
        bus.exact_sum = 17'h0_0100;
        compared++;
        if (bus.in_ready !== 1'b0) begin
            $display("FAIL stall_extra_ready got %b expected 0", bus.in_ready);
            failed++;
        end
        step();
        compared++;
        if ({done, sample_count} !== {1'b0, 24'd2}) begin
            $display("FAIL stall_t1 got done=%b cnt=%0d expected 0/2", done, sample_count);
            failed++;
        end
        step();
        compared++;
        if ({done, busy, sample_count, err_count, sum_ed, max_ed} !==
            {1'b1, 1'b0, 24'd2, 24'd2, 40'd9, 17'd7}) begin
            $display("FAIL stall_t2 got done=%b busy=%b cnt=%0d err=%0d sum=%h max=%h expected 1/0/2/2/9/7",
                     done, busy, sample_count, err_count, sum_ed, max_ed);
            failed++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_zero_restart();
        // start and in_valid together in DONE: start wins, no sample taken.
        bus.in_valid   = 1'b1;
        bus.exact_sum  = 17'h0_0009;
        bus.approx_sum = 17'h0_0000;
        compared++;
        if (bus.in_ready !== 1'b0) begin
            $display("FAIL zero_ready_in_done got %b expected 0", bus.in_ready);
            failed++;
        end
        do_start(24'd0);
        bus.in_valid = 1'b0;
        compared++;
        if ({done, busy, sample_count, err_count, sum_ed, max_ed, acc_sat} !=
            {1'b1, 1'b0, 24'd0, 24'd0, 40'd0, 17'd0, 1'b0}) begin
            $display("FAIL zero_run got done=%b busy=%b cnt=%0d err=%0d sum=%h max=%h expected 1/0/0/0/0/0",
                     done, busy, sample_count, err_count, sum_ed, max_ed);
            failed++;
        end
        do_start(24'd5);
        send(17'h0_0001, 17'h0_0000, "restart0");
        send(17'h0_0002, 17'h0_0001, "restart1");
        bus.in_valid = 1'b0;
        start = 1'b1;
        num_samples = 24'd1;
        step();
        start = 1'b0;
        send(17'h0_0003, 17'h0_0002, "restart2");
        send(17'h0_0004, 17'h0_0003, "restart3");
        send(17'h0_0005, 17'h0_0004, "restart4");
        bus.in_valid = 1'b0;
        step();
        step();
        compared++;
        if ({done, sample_count, err_count, sum_ed, max_ed} !==
            {1'b1, 24'd5, 24'd5, 40'd5, 17'd1}) begin
            $display("FAIL restart_ignored got done=%b cnt=%0d err=%0d sum=%h max=%h expected 1/5/5/5/1",
                     done, sample_count, err_count, sum_ed, max_ed);
            failed++;
        end
    endtask

    task automatic test_saturation();
        start2 = 1'b1;
        num_samples2 = 24'd3;
        step();
        start2 = 1'b0;
        bus2.in_valid   = 1'b1;
        bus2.exact_sum  = 17'h1_FFFF;
        bus2.approx_sum = 17'h0_0000;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (bus2.in_ready !== 1'b1) begin
                $display("FAIL sat_in_ready got %b expected 1", bus2.in_ready);
                failed++;
            end
            step();
        end
        bus2.in_valid = 1'b0;
        step();
        step();
        compared++;
        if ({done2, sum_ed2, acc_sat2, max_ed2, sample_count2} !==
            {1'b1, 17'h1_FFFF, 1'b1, 17'h1_FFFF, 24'd3}) begin
            $display("FAIL sat_result got done=%b sum=%h sat=%b max=%h cnt=%0d expected 1/1ffff/1/1ffff/3",
                     done2, sum_ed2, acc_sat2, max_ed2, sample_count2);
            failed++;
        end
        step();
        step();
        compared++;
        if ({sum_ed2, acc_sat2} !== {17'h1_FFFF, 1'b1}) begin
            $display("FAIL sat_hold got sum=%h sat=%b expected 1ffff/1", sum_ed2, acc_sat2);
            failed++;
        end
        start2 = 1'b1;
        num_samples2 = 24'd1;
        step();
        start2 = 1'b0;
        compared++;
        if ({sum_ed2, acc_sat2, done2, busy2} !== {17'h0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL sat_clear got sum=%h sat=%b done=%b busy=%b expected 0/0/0/1",
                     sum_ed2, acc_sat2, done2, busy2);
            failed++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        num_samples = '0;
        start2 = 1'b0;
        num_samples2 = '0;
        bus.in_valid = 1'b0;
        bus.exact_sum = '0;
        bus.approx_sum = '0;
        bus2.in_valid = 1'b0;
        bus2.exact_sum = '0;
        bus2.approx_sum = '0;
        #1;
        test_reset();
        test_exact_b2b();
        test_mixed();
        test_stall();
        test_zero_restart();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
